// File: rtl/branch_resolver_if.sv
// ============================================================================
// Module   : branch_resolver_if
// Brief    : Fetch / predictor / execute handshake bundle for branch_resolver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                       fetch_br;
    logic                       fetch_stall;
    logic                       pred_req;
    logic                       pred_in;
    logic                       resolve_valid;
    logic                       resolve_taken;
    logic                       resolve_ready;
    logic                       fb_result;
    logic                       fb_taken;
    logic                       mispredict;
    logic                       resolve_err;
    logic [$clog2(DEPTH):0]     occupancy;
    logic [CNT_W-1:0]           br_total;
    logic [CNT_W-1:0]           br_miss;

    // Environment side: fetch, predictor and execute.
    modport master (
        output fetch_br, pred_in, resolve_valid, resolve_taken,
        input  fetch_stall, pred_req, resolve_ready, fb_result, fb_taken,
               mispredict, resolve_err, occupancy, br_total, br_miss
    );

    // Resolver side.
    modport slave (
        input  fetch_br, pred_in, resolve_valid, resolve_taken,
        output fetch_stall, pred_req, resolve_ready, fb_result, fb_taken,
               mispredict, resolve_err, occupancy, br_total, br_miss
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module   : branch_resolver
// Brief    : In-order branch prediction tracking queue with mispredict flush.
//            Optional statistics counters under BRANCH_RESOLVER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    branch_resolver_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);

    logic [DEPTH-1:0]   r_pred;
    logic [DEPTH-1:0]   r_filled;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W-1:0]   r_cap_ptr;
    logic               r_cap_pend;
    logic [OCC_W-1:0]   r_occ;
    logic               r_fb_result;
    logic               r_fb_taken;
    logic               r_mispredict;
    logic               r_resolve_err;

    logic               w_stall;
    logic               w_req;
    logic               w_ready;
    logic               w_accept;
    logic               w_miss;
    logic               w_alloc;
    logic               w_pop;
    logic [OCC_W-1:0]   w_occ_nxt;

    assign w_stall  = (r_occ == C_FULL);
    assign w_req    = bus.fetch_br & ~w_stall;
    assign w_ready  = (r_occ != '0) & r_filled[r_head];
    assign w_accept = bus.resolve_valid & w_ready;
    assign w_miss   = w_accept & (bus.resolve_taken != r_pred[r_head]);
    // A flushing accept swallows any same-cycle allocation.
    assign w_alloc  = w_req & ~w_miss;
    assign w_pop    = w_accept & ~w_miss;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_alloc, w_pop})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred     <= '0;
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cap_ptr  <= '0;
            r_cap_pend <= 1'b0;
            r_occ      <= '0;
        end else if (w_miss) begin
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cap_pend <= 1'b0;
            r_occ      <= '0;
        end else begin
            // Capture, pop and allocate never hit the same slot: the captured
            // slot is unfilled so cannot be head, and head==tail only when
            // empty (no pop) or full (no alloc).
            if (r_cap_pend) begin
                r_pred[r_cap_ptr]   <= bus.pred_in;
                r_filled[r_cap_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_filled[r_tail] <= 1'b0;
                r_cap_ptr        <= r_tail;
                r_tail           <= r_tail + 1'b1;
            end
            r_cap_pend <= w_alloc;
            r_occ      <= w_occ_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb_result   <= 1'b0;
            r_fb_taken    <= 1'b0;
            r_mispredict  <= 1'b0;
            r_resolve_err <= 1'b0;
        end else begin
            r_fb_result   <= w_accept;
            r_fb_taken    <= w_accept & bus.resolve_taken;
            r_mispredict  <= w_miss;
            r_resolve_err <= bus.resolve_valid & ~w_ready;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total    <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept && (r_total != '1))
                r_total <= r_total + 1'b1;
            if (w_miss && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.br_total = r_total;
    assign bus.br_miss  = r_miss_cnt;
`else
    assign bus.br_total = {CNT_W{1'b0}};
    assign bus.br_miss  = {CNT_W{1'b0}};
`endif

    assign bus.fetch_stall   = w_stall;
    assign bus.pred_req      = w_req;
    assign bus.resolve_ready = w_ready;
    assign bus.fb_result     = r_fb_result;
    assign bus.fb_taken      = r_fb_taken;
    assign bus.mispredict    = r_mispredict;
    assign bus.resolve_err   = r_resolve_err;
    assign bus.occupancy     = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// Module   : tb_branch_resolver
// Brief    : Randomized scoreboard bench for branch_resolver against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolver;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int NCYC   = 2000;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    bit   clk = 1'b0;
    logic rst;

    branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit filled;
        bit pred;
    } ent_t;

    typedef struct {
        bit stall, req, ready, fbr, fbt, mis, err;
        int occ, tot, miss;
    } exp_t;

    // Reference model: entry list plus last-edge registered outputs.
    ent_t mq[$];
    bit   m_pend;
    bit   m_fbr, m_fbt, m_mis, m_err;
    int   m_tot, m_miss;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;
    int   pushed = 0;
    int   popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_fbr  = 1'b0;
        m_fbt  = 1'b0;
        m_mis  = 1'b0;
        m_err  = 1'b0;
        m_tot  = 0;
        m_miss = 0;
    endtask

    // Monitor: compares whatever the DUT shows mid-cycle with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                popped++;
                chk("fetch_stall",   32'(bus.fetch_stall),   32'(e.stall));
                chk("pred_req",      32'(bus.pred_req),      32'(e.req));
                chk("resolve_ready", 32'(bus.resolve_ready), 32'(e.ready));
                chk("fb_result",     32'(bus.fb_result),     32'(e.fbr));
                chk("fb_taken",      32'(bus.fb_taken),      32'(e.fbt));
                chk("mispredict",    32'(bus.mispredict),    32'(e.mis));
                chk("resolve_err",   32'(bus.resolve_err),   32'(e.err));
                chk("occupancy",     32'(bus.occupancy),     32'(e.occ));
                chk("br_total",      32'(bus.br_total),      32'(e.tot));
                chk("br_miss",       32'(bus.br_miss),       32'(e.miss));
            end
        end
    end

    initial begin
        bit   r, fb, pi, rv, rt;
        bit   ready, stall, req, acc, miss;
        int   phase;
        exp_t e;

        rst                = 1'b1;
        bus.fetch_br       = 1'b0;
        bus.pred_in        = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #2;
            r     = (cyc < 3) || (cyc >= 1000 && cyc < 1003);
            phase = (cyc / 125) % 4;

            case (phase)
                0: begin fb = ($urandom_range(0, 99) < 50); rv = ($urandom_range(0, 99) < 50); end
                1: begin fb = ($urandom_range(0, 99) < 90); rv = ($urandom_range(0, 99) < 10); end
                2: begin fb = ($urandom_range(0, 99) < 40); rv = ($urandom_range(0, 99) < 80); end
                default: begin fb = $urandom_range(0, 1); rv = $urandom_range(0, 1); end
            endcase
            pi = $urandom_range(0, 1);
            if (mq.size() > 0 && mq[0].filled && $urandom_range(0, 99) < 75)
                rt = mq[0].pred;
            else
                rt = $urandom_range(0, 1);

            rst               = r;
            bus.fetch_br      = fb;
            bus.pred_in       = pi;
            bus.resolve_valid = rv;
            bus.resolve_taken = rt;

            if (r) model_reset();

            ready = (mq.size() > 0) && mq[0].filled;
            stall = (mq.size() == DEPTH);
            req   = fb && !stall;

            e.stall = stall;
            e.req   = req;
            e.ready = ready;
            e.fbr   = m_fbr;
            e.fbt   = m_fbt;
            e.mis   = m_mis;
            e.err   = m_err;
            e.occ   = mq.size();
            e.tot   = m_tot;
            e.miss  = m_miss;
            sbq.push_back(e);
            pushed++;

            if (!r) begin
                acc   = rv && ready;
                miss  = acc && (rt != mq[0].pred);
                m_fbr = acc;
                m_fbt = acc && rt;
                m_mis = miss;
                m_err = rv && !ready;
`ifdef BRANCH_RESOLVER_STATS_EN
                if (acc  && m_tot  < CNTMAX) m_tot++;
                if (miss && m_miss < CNTMAX) m_miss++;
`endif
                if (miss) begin
                    mq.delete();
                    m_pend = 1'b0;
                end else begin
                    if (m_pend) mq[mq.size() - 1] = '{filled: 1'b1, pred: pi};
                    if (acc) void'(mq.pop_front());
                    if (req) mq.push_back('{filled: 1'b0, pred: 1'b0});
                    m_pend = req;
                end
            end
        end

        @(posedge clk);
        #2;
        bus.fetch_br      = 1'b0;
        bus.resolve_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", 32'(popped), 32'(pushed));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
